// File: rtl/dec_scan.sv
// Registered one-hot decoder with an auto-scan sequencer.
// Direct mode decodes sel; scan mode steps through every channel, holding each for DWELL cycles.
module dec_scan #(
    parameter int SEL_W = 4,
    parameter int DWELL = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel,
    output logic [(1<<SEL_W)-1:0]  out,
    output logic [SEL_W-1:0]       idx,
    output logic                   valid,
    output logic                   wrap
);

    // state  | meaning
    // IDLE   | blanked (en low or just out of reset), out = 0
    // DIRECT | out decodes sel every cycle
    // SCAN   | out steps through channels, DWELL cycles per channel

    localparam int N  = 1 << SEL_W;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] DWELL_TC  = CW'(DWELL - 1);
    localparam logic [N-1:0]  ONE_HOT_0 = N'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  idx_q, idx_d;
    logic [N-1:0]      out_q, out_d;
    logic              valid_q, valid_d;
    logic              wrap_q, wrap_d;
    // Dwell cycles still to go on the current channel; channel advances when it reaches zero.
    logic [CW-1:0]     dwell_q, dwell_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            dwell_q <= DWELL_TC;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            dwell_q <= dwell_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        out_d   = out_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;
        dwell_d = dwell_q;

        if (!en) begin
            state_d = IDLE;
            out_d   = '0;
            valid_d = 1'b0;
            dwell_d = DWELL_TC;
        end else if (!mode || state_q != SCAN) begin
            // Direct decode, or the first cycle of a scan starting at sel.
            state_d = mode ? SCAN : DIRECT;
            idx_d   = sel;
            out_d   = ONE_HOT_0 << sel;
            valid_d = 1'b1;
            dwell_d = DWELL_TC;
        end else if (dwell_q != '0) begin
            dwell_d = dwell_q - 1'b1;
        end else begin
            dwell_d = DWELL_TC;
            idx_d   = idx_q + 1'b1;
            out_d   = ONE_HOT_0 << idx_d;
            wrap_d  = &idx_q;
        end
    end

    assign out   = out_q;
    assign idx   = idx_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_dec_scan.sv
// Directed bench for dec_scan: main instance SEL_W=4/DWELL=3 plus SEL_W=1 and SEL_W=8 corners with DWELL=1.
module tb_dec_scan;

    logic         clk = 1'b0;
    logic         rst, en, mode;
    logic [3:0]   sel;
    logic [15:0]  out;
    logic [3:0]   idx;
    logic         valid, wrap;

    logic [0:0]   sel1;
    logic [1:0]   out1;
    logic [0:0]   idx1;
    logic         valid1, wrap1;

    logic [7:0]   sel8;
    logic [255:0] out8;
    logic [7:0]   idx8;
    logic         valid8, wrap8;

    int tests_run = 0;
    int fail_cnt  = 0;

    always #5 clk = ~clk;

    dec_scan #(.SEL_W(4), .DWELL(3)) u_dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
        .out(out), .idx(idx), .valid(valid), .wrap(wrap)
    );

    dec_scan #(.SEL_W(1), .DWELL(1)) u_s1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel1),
        .out(out1), .idx(idx1), .valid(valid1), .wrap(wrap1)
    );

    dec_scan #(.SEL_W(8), .DWELL(1)) u_s8 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel8),
        .out(out8), .idx(idx8), .valid(valid8), .wrap(wrap8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks main-instance outputs against hand-computed values.
    task automatic expect_main(input string name, input logic [15:0] e_out, input logic [3:0] e_idx,
                               input logic e_valid, input logic e_wrap);
        tests_run++;
        if (out !== e_out || idx !== e_idx || valid !== e_valid || wrap !== e_wrap) begin
            fail_cnt++;
            $display("FAIL %s: got out=%h idx=%0d valid=%b wrap=%b, expected out=%h idx=%0d valid=%b wrap=%b",
                     name, out, idx, valid, wrap, e_out, e_idx, e_valid, e_wrap);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; mode = 1'b1; sel = 4'd5; sel1 = 1'b0; sel8 = 8'd0;
        step();
        step();
        expect_main("reset", 16'h0000, 4'd0, 1'b0, 1'b0);
        rst = 1'b0; en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_main("blank", 16'h0000, 4'd0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_direct();
        logic [15:0] e;
        en = 1'b1; mode = 1'b0;
        for (int s = 0; s < 16; s++) begin
            sel = 4'(s);
            step();
            e = 16'h0001 << s;
            expect_main("direct_up", e, 4'(s), 1'b1, 1'b0);
        end
        for (int s = 15; s >= 0; s--) begin
            sel = 4'(s);
            step();
            e = 16'h0001 << s;
            expect_main("direct_down", e, 4'(s), 1'b1, 1'b0);
        end
    endtask

    task automatic test_scan_wrap();
        int ch;
        int wraps;
        logic [15:0] e;
        logic ew;
        wraps = 0;
        mode = 1'b1; sel = 4'd14;
        step();
        sel = 4'd3;
        expect_main("scan_entry", 16'h4000, 4'd14, 1'b1, 1'b0);
        for (int c = 1; c < 96; c++) begin
            step();
            ch = (14 + c / 3) % 16;
            ew = (c % 3 == 0) && (ch == 0);
            e  = 16'h0001 << ch;
            expect_main("scan_lap", e, 4'(ch), 1'b1, ew);
            if (wrap === 1'b1) wraps++;
        end
        tests_run++;
        if (wraps !== 2) begin
            fail_cnt++;
            $display("FAIL scan_wrap_count: got %0d, expected 2", wraps);
        end
    endtask

    task automatic test_mode_change();
        mode = 1'b0; sel = 4'd5;
        step();
        expect_main("mc_direct5", 16'h0020, 4'd5, 1'b1, 1'b0);
        mode = 1'b1;
        step();
        expect_main("mc_scan5", 16'h0020, 4'd5, 1'b1, 1'b0);
        mode = 1'b0; sel = 4'd9;
        step();
        expect_main("mc_to_direct", 16'h0200, 4'd9, 1'b1, 1'b0);
        mode = 1'b1; sel = 4'd2;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_main("mc_rescan2", 16'h0004, 4'd2, 1'b1, 1'b0);
        end
        step();
        expect_main("mc_rescan3", 16'h0008, 4'd3, 1'b1, 1'b0);
    endtask

    task automatic test_rst_en_mid();
        mode = 1'b0; sel = 4'd7;
        step();
        mode = 1'b1;
        step();
        step();
        expect_main("mid_dwell7", 16'h0080, 4'd7, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        expect_main("mid_rst", 16'h0000, 4'd0, 1'b0, 1'b0);
        rst = 1'b0; sel = 4'd11;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_main("post_rst_scan11", 16'h0800, 4'd11, 1'b1, 1'b0);
        end
        step();
        expect_main("post_rst_scan12", 16'h1000, 4'd12, 1'b1, 1'b0);
        en = 1'b0;
        step();
        expect_main("en_blank", 16'h0000, 4'd12, 1'b0, 1'b0);
        en = 1'b1; sel = 4'd4;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_main("en_restart4", 16'h0010, 4'd4, 1'b1, 1'b0);
        end
        step();
        expect_main("en_restart5", 16'h0020, 4'd5, 1'b1, 1'b0);
    endtask

    task automatic test_corners();
        logic [255:0] e8;
        logic [1:0]   e1;
        logic         ew;
        int           wraps8;
        wraps8 = 0;
        rst = 1'b1;
        step();
        rst = 1'b0; en = 1'b1; mode = 1'b1; sel1 = 1'b0; sel8 = 8'd0;
        for (int c = 0; c <= 512; c++) begin
            step();
            if (c < 8) begin
                e1 = (c % 2 == 0) ? 2'b01 : 2'b10;
                ew = (c > 0) && (c % 2 == 0);
                tests_run++;
                if (out1 !== e1 || idx1 !== 1'(c % 2) || valid1 !== 1'b1 || wrap1 !== ew) begin
                    fail_cnt++;
                    $display("FAIL corner_sel1 c=%0d: got out=%b idx=%0d wrap=%b, expected out=%b idx=%0d wrap=%b",
                             c, out1, idx1, wrap1, e1, c % 2, ew);
                end
            end
            e8 = 256'd1 << (c % 256);
            ew = (c > 0) && (c % 256 == 0);
            if (wrap8 === 1'b1) wraps8++;
            if (c % 32 == 0 || ew || c % 256 == 255) begin
                tests_run++;
                if (out8 !== e8 || idx8 !== 8'(c % 256) || valid8 !== 1'b1 || wrap8 !== ew) begin
                    fail_cnt++;
                    $display("FAIL corner_sel8 c=%0d: got idx=%0d wrap=%b valid=%b, expected idx=%0d wrap=%b valid=1",
                             c, idx8, wrap8, valid8, c % 256, ew);
                end
            end
        end
        tests_run++;
        if (wraps8 !== 2) begin
            fail_cnt++;
            $display("FAIL corner_sel8_wraps: got %0d, expected 2", wraps8);
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_scan_wrap();
        test_mode_change();
        test_rst_en_mid();
        test_corners();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule

// File: doc/dec_scan.md
# dec_scan

Parametrised registered one-hot decoder with a built-in auto-scan sequencer. It turns a SEL_W-bit index into a 2^SEL_W-wide one-hot output in direct mode. In scan mode it steps the one-hot output through every channel, holding each for DWELL cycles. It is the sequential successor to the team's fixed 4-to-16 gate-level decoder and sits between control logic and multiplexed loads: display digit/column drivers, bank selects and round-robin strobes.

## Interface

Parameters:
- SEL_W, 4, index width; output width N = 2^SEL_W; legal range 1..8
- DWELL, 4, cycles each channel is held in scan mode; legal range 1..65535

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  reset; synchronous and active-high
- en  input  1  block enable; 0 blanks outputs
- mode  input  1  0 = direct decode, 1 = auto-scan
- sel  input  SEL_W  direct-mode index, also the scan start index
- out  output  N  registered one-hot output; bit k is high when channel k is selected
- idx  output  SEL_W  registered index currently driven on out
- valid  output  1  out holds a live one-hot value
- wrap  output  1  one-cycle pulse when a scan passes from channel N-1 to channel 0

## Operation

- Internal state: st ∈ {IDLE, DIRECT, SCAN}, plus dwell counter dcnt, sized to count 0..DWELL-1.
- Reset (rst=1 at a clk edge): st=IDLE, out=0, idx=0, valid=0, wrap=0, dcnt=0. rst has priority over all other inputs, including in the middle of a scan.
- Next-state rules, evaluated every edge when rst=0:
  - en=0: goes to IDLE. out=0, valid=0, wrap=0, dcnt=0. idx holds its last value.
  - en=1, mode=0: goes to DIRECT. idx=sel, out=1<<sel, valid=1, wrap=0, dcnt=0. sel is re-sampled every cycle.
  - en=1, mode=1, entered from IDLE or DIRECT: goes to SCAN. idx=sel, out=1<<sel, valid=1, dcnt=0, wrap=0. The scan starts at the current sel.
  - en=1, mode=1, already in SCAN:
    - If dcnt < DWELL-1: dcnt increments and idx/out hold.
    - Otherwise: dcnt=0 and idx=(idx+1) mod N, with out following. wrap=1 only when the old idx was N-1; otherwise wrap=0.
    - sel is ignored while scanning.
- Invariants:
  - valid=1 implies out has exactly one bit set and that bit is bit idx.
  - valid=0 implies out=0.
  - wrap is never high when valid=0.
- Index arithmetic is modulo N; no out-of-range index exists.
- With DWELL=1 the index advances every cycle.
- With SEL_W=1, N=2 and the scan toggles between the two channels.

## Timing

- Latency: all outputs are registered. An input change at edge t is visible after edge t, i.e. one cycle of latency. There is no combinational path from input to output.
- In scan, each channel is shown for exactly DWELL consecutive cycles. The full period is N·DWELL cycles.
- wrap rises together with out becoming 1<<0 after channel N-1, and lasts 1 cycle.
- Mode changes:
  - Scan→direct takes effect on the next edge, decoding the current sel, and aborts the dwell.
  - Direct→scan restarts the scan at sel with a full dwell.
- An en pulse low for one cycle blanks out for one cycle and restarts any scan at sel.
- After rst deasserts, the first live output appears one cycle after the first edge with en=1.

## Test plan

All scenarios use SEL_W=4, DWELL=3.

1. Reset/blank: assert rst for 2 cycles with en=1, mode=1 → out=0, idx=0, valid=0, wrap=0. Then hold en=0 for 5 cycles → outputs stay 0.
2. Direct sweep: en=1, mode=0, sel=0..15 applied one per cycle → each cycle after, out=1<<sel, idx=sel, valid=1, wrap=0. Also run a full exhaustive compare against a one-hot model.
3. Scan with wrap: mode=1, sel=14 → out=0x4000 for 3 cycles, then 0x8000 for 3 cycles, then 0x0001 with wrap=1 for its first cycle only. idx follows 14, 15, 0, 1. The 48-cycle period is checked over two full laps.
4. Mid-scan mode change: while scanning at idx=5 after 1 dwell cycle, set mode=0, sel=9 → next cycle out=0x0200. Then set mode=1, sel=2 → the scan resumes from channel 2 with a full 3-cycle dwell.
5. Reset and enable mid-operation:
   - rst pulse during dwell at idx=7 → next cycle all outputs are 0. With rst low, the scan restarts at sel.
   - A one-cycle en=0 → exactly one blank cycle, then the scan restarts at sel.
6. Parameter corners: rebuild with SEL_W=1, DWELL=1 → out alternates 01/10 every cycle and wrap pulses every 2 cycles. Rebuild with SEL_W=8, DWELL=1 → a 256-cycle period with exactly one wrap per lap.
